// File: rtl/che_pkg.sv
// Shared CHE datapath constants and the histogram reader FSM state type.
// The defaults below are also used by the CDF adder tree.
package che_pkg;

  localparam int unsigned BIN_WD_DEF   = 16;
  localparam int unsigned BIN_NUM_DEF  = 256;
  localparam int unsigned PACK_NUM_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/che_hist_pack.sv
// Lane pack register for the histogram reader: collects returned bins by lane
// and launches a full beat on the adder-tree vld/dat interface.
module che_hist_pack
  import che_pkg::*;
#(
  parameter int unsigned BIN_WD   = BIN_WD_DEF,
  parameter int unsigned PACK_NUM = PACK_NUM_DEF,
  parameter int unsigned LANE_WD  = $clog2(PACK_NUM)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ret_vld,
  input  logic [LANE_WD-1:0]           lane,
  input  logic [BIN_WD-1:0]            dat,
  output logic                         vld,
  output logic [BIN_WD*PACK_NUM-1:0]   pack_dat
);

  // Only lanes 0..PACK_NUM-2 need storage; the last lane goes straight into the beat.
  logic [BIN_WD*(PACK_NUM-1)-1:0] pack;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack     <= '0;
      vld      <= 1'b0;
      pack_dat <= '0;
    end else begin
      vld <= 1'b0;
      if (ret_vld) begin
        if (lane == LANE_WD'(PACK_NUM - 1)) begin
          pack_dat <= {dat, pack};
          vld      <= 1'b1;
        end else begin
          pack[BIN_WD*lane +: BIN_WD] <= dat;
        end
      end
    end
  end

endmodule

// File: rtl/che_hist_reader.sv
// Sequential histogram-RAM reader feeding the CHE CDF adder tree.
// Define CHE_HIST_CLR_EN to zero each bin in the RAM as it is returned.
module che_hist_reader
  import che_pkg::*;
#(
  parameter int unsigned BIN_WD   = BIN_WD_DEF,
  parameter int unsigned BIN_NUM  = BIN_NUM_DEF,
  parameter int unsigned ADDR_WD  = 8,
  parameter int unsigned PACK_NUM = PACK_NUM_DEF,
  parameter int unsigned RAM_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        ram_rd_o,
  output logic [ADDR_WD-1:0]          ram_addr_o,
  input  logic [BIN_WD-1:0]           ram_dat_i,
  output logic                        ram_wr_o,
  output logic [ADDR_WD-1:0]          ram_waddr_o,
  output logic [BIN_WD-1:0]           ram_wdat_o,
  output logic                        vld_o,
  output logic [BIN_WD*PACK_NUM-1:0]  dat_o
);

  localparam int unsigned LANE_WD = $clog2(PACK_NUM);

  state_t               state;
  logic [RAM_LAT-1:0]   rd_sr;
  logic [ADDR_WD-1:0]   addr_sr [RAM_LAT];
  logic                 ret_vld;
  logic [ADDR_WD-1:0]   ret_addr;
  logic                 last_ret;

  assign ret_vld  = rd_sr[RAM_LAT-1];
  assign ret_addr = addr_sr[RAM_LAT-1];
  assign last_ret = ret_vld && (ret_addr == ADDR_WD'(BIN_NUM - 1));

  // done_o is raised by the last return; DRAIN exits in the cycle done_o is high,
  // so busy_o covers the final beat and start_i is ignored there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ram_rd_o   <= 1'b0;
      ram_addr_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state      <= ST_RD;
            busy_o     <= 1'b1;
            ram_rd_o   <= 1'b1;
            ram_addr_o <= '0;
          end
        end
        ST_RD: begin
          if (ram_addr_o == ADDR_WD'(BIN_NUM - 1)) begin
            state      <= ST_DRAIN;
            ram_rd_o   <= 1'b0;
            ram_addr_o <= '0;
          end else begin
            ram_addr_o <= ram_addr_o + ADDR_WD'(1);
          end
        end
        ST_DRAIN: begin
          if (done_o) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (last_ret) begin
            done_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_sr <= '0;
      for (int unsigned i = 0; i < RAM_LAT; i++) addr_sr[i] <= '0;
    end else begin
      rd_sr[0]   <= ram_rd_o;
      addr_sr[0] <= ram_addr_o;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        rd_sr[i]   <= rd_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
    end
  end

`ifdef CHE_HIST_CLR_EN
  assign ram_wr_o    = ret_vld;
  assign ram_waddr_o = ret_addr;
  assign ram_wdat_o  = '0;
`else
  assign ram_wr_o    = 1'b0;
  assign ram_waddr_o = '0;
  assign ram_wdat_o  = '0;
`endif

  che_hist_pack #(
    .BIN_WD   (BIN_WD),
    .PACK_NUM (PACK_NUM),
    .LANE_WD  (LANE_WD)
  ) u_pack (
    .clk      (clk),
    .rstn     (rstn),
    .ret_vld  (ret_vld),
    .lane     (ret_addr[LANE_WD-1:0]),
    .dat      (ram_dat_i),
    .vld      (vld_o),
    .pack_dat (dat_o)
  );

endmodule

// File: tb/tb_che_hist_reader.sv
// Bench for che_hist_reader: a RAM_LAT=1 instance with a beat scoreboard and a
// RAM_LAT=2 instance checked for beat timing and data.
module tb_che_hist_reader;

  localparam int BW   = 16;
  localparam int BN   = 256;
  localparam int AW   = 8;
  localparam int PN   = 8;
  localparam int DW   = BW * PN;
  localparam int LAT  = 1;
  localparam int LAT2 = 2;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic          busy, done, ram_rd, ram_wr, vld;
  logic [AW-1:0] ram_addr, ram_waddr;
  logic [BW-1:0] ram_dat, ram_wdat;
  logic [DW-1:0] dat;

  logic          busy2, done2, ram_rd2, ram_wr2, vld2;
  logic [AW-1:0] ram_addr2, ram_waddr2;
  logic [BW-1:0] ram_dat2, ram_wdat2, d2a;
  logic [DW-1:0] dat2;

  che_hist_reader #(.BIN_WD(BW), .BIN_NUM(BN), .ADDR_WD(AW), .PACK_NUM(PN), .RAM_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .start_i(start), .busy_o(busy), .done_o(done),
    .ram_rd_o(ram_rd), .ram_addr_o(ram_addr), .ram_dat_i(ram_dat),
    .ram_wr_o(ram_wr), .ram_waddr_o(ram_waddr), .ram_wdat_o(ram_wdat),
    .vld_o(vld), .dat_o(dat)
  );

  che_hist_reader #(.BIN_WD(BW), .BIN_NUM(BN), .ADDR_WD(AW), .PACK_NUM(PN), .RAM_LAT(LAT2)) dut2 (
    .clk(clk), .rstn(rstn), .start_i(start), .busy_o(busy2), .done_o(done2),
    .ram_rd_o(ram_rd2), .ram_addr_o(ram_addr2), .ram_dat_i(ram_dat2),
    .ram_wr_o(ram_wr2), .ram_waddr_o(ram_waddr2), .ram_wdat_o(ram_wdat2),
    .vld_o(vld2), .dat_o(dat2)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int s1 = -1000;
  int s2 = -1000;
  int b2 = 0;
  bit mon_en = 1'b0;
  logic fill_req = 1'b0;
  logic fill_ff = 1'b0;

  logic [BW-1:0] mem [BN];
  logic [BW-1:0] exp_mem [BN];

  typedef struct {
    int            cyc;
    logic [DW-1:0] dat;
  } beat_t;
  beat_t q[$];
  beat_t e;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM for the LAT=1 instance: one-cycle read, honours clear writes.
  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < BN; i++) mem[i] <= fill_ff ? 16'hFFFF : BW'(i);
    end else if (ram_wr) begin
      mem[ram_waddr] <= ram_wdat;
    end
    if (ram_rd) ram_dat <= mem[ram_addr];
  end

  function automatic logic [BW-1:0] f2(int i);
    return BW'(i * 37 + 5);
  endfunction

  function automatic logic [DW-1:0] beat2(int b);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < PN; k++) r[BW*k +: BW] = f2(b * PN + k);
    return r;
  endfunction

  // Read-only RAM for the LAT=2 instance.
  always @(posedge clk) begin
    if (ram_rd2) d2a <= f2(int'(ram_addr2));
    ram_dat2 <= d2a;
  end

  task automatic chk1(string tag, logic obs, logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkw(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk1("busy", busy, cyc >= s1 + 1 && cyc <= s1 + BN + LAT + 1);
      chk1("done", done, cyc == s1 + BN + LAT + 1);
      chk1("ram_rd", ram_rd, cyc >= s1 + 1 && cyc <= s1 + BN);
      if (ram_rd) chkw("ram_addr", DW'(ram_addr), DW'(cyc - s1 - 1));
`ifdef CHE_HIST_CLR_EN
      chk1("ram_wr", ram_wr, cyc >= s1 + LAT + 1 && cyc <= s1 + LAT + BN);
      if (ram_wr) begin
        chkw("ram_waddr", DW'(ram_waddr), DW'(cyc - s1 - LAT - 1));
        chkw("ram_wdat", DW'(ram_wdat), '0);
      end
`else
      chk1("ram_wr", ram_wr, 1'b0);
      chkw("ram_waddr", DW'(ram_waddr), '0);
      chkw("ram_wdat", DW'(ram_wdat), '0);
`endif
      if (vld) begin
        if (q.size() == 0) begin
          chk1("unexpected_vld", vld, 1'b0);
        end else begin
          e = q.pop_front();
          chkw("vld_cycle", DW'(cyc), DW'(e.cyc));
          chkw("beat_dat", dat, e.dat);
        end
      end
      chk1("busy2", busy2, cyc >= s2 + 1 && cyc <= s2 + BN + LAT2 + 1);
      chk1("done2", done2, cyc == s2 + BN + LAT2 + 1);
      if (vld2) begin
        chkw("vld2_cycle", DW'(cyc), DW'(s2 + (b2 + 1) * PN + LAT2 + 1));
        chkw("beat2_dat", dat2, beat2(b2));
        b2++;
      end
    end
  end

  task automatic wait_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(logic ff);
    fill_ff  = ff;
    fill_req = 1'b1;
    for (int i = 0; i < BN; i++) exp_mem[i] = ff ? 16'hFFFF : BW'(i);
    @(posedge clk);
    #1;
    fill_req = 1'b0;
  endtask

  // Pulse start in cycle c; expectations are queued only where the reader is idle.
  task automatic start_at(int c);
    beat_t nb;
    wait_to(c);
    start = 1'b1;
    if (cyc >= s1 + BN + LAT + 2) begin
      s1 = cyc;
      for (int b = 0; b < BN / PN; b++) begin
        nb.cyc = cyc + (b + 1) * PN + LAT + 1;
        for (int k = 0; k < PN; k++) nb.dat[BW*k +: BW] = exp_mem[b * PN + k];
        q.push_back(nb);
      end
`ifdef CHE_HIST_CLR_EN
      for (int i = 0; i < BN; i++) exp_mem[i] = '0;
`endif
    end
    if (cyc >= s2 + BN + LAT2 + 2) begin
      s2 = cyc;
      b2 = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  int s;

  initial begin
    #2 rstn = 1'b0;
    @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_rd", ram_rd, 1'b0);
    chk1("rst_vld", vld, 1'b0);
    chkw("rst_dat", dat, '0);
    rstn = 1'b1;
    fill(1'b0);
    mon_en = 1'b1;

    // Basic scan with ignored starts mid-scan and on the done cycle, then
    // the earliest legal restart (too early for the LAT=2 instance).
    s = cyc + 2;
    start_at(s);
    start_at(s + 50);
    start_at(s + BN + LAT + 1);
    start_at(s + BN + LAT + 2);
    s = s + BN + LAT + 2;
    wait_to(s + BN + 20);

    // Saturated bins must pass through every lane unchanged.
    fill(1'b1);
    s = cyc + 1;
    start_at(s);
    wait_to(s + BN + 20);

    // Asynchronous reset in the middle of a scan.
    fill(1'b0);
    s = cyc + 1;
    start_at(s);
    wait_to(s + 100);
    rstn = 1'b0;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_rd", ram_rd, 1'b0);
    chk1("mid_rst_wr", ram_wr, 1'b0);
    chk1("mid_rst_vld", vld, 1'b0);
    chkw("mid_rst_dat", dat, '0);
    chk1("mid_rst_busy2", busy2, 1'b0);
    q.delete();
    s1 = -1000;
    s2 = -1000;
    b2 = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    fill(1'b0);
    wait_to(cyc + 20);

    s = cyc;
    start_at(s);
    wait_to(s + BN + 20);

    chk1("queue_empty", q.size() == 0, 1'b1);
    chk1("beats2_seen", b2 == BN / PN, 1'b1);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
